// File: rtl/mfi_pkg.sv
// Shared types for the MFI retire tracker: datapath widths, FSM state
// encoding, the retire packet layout and a helper that builds a fresh packet
// at instruction issue.
package mfi_pkg;

    localparam int XLEN   = 32;
    localparam int REG_W  = 4;
    localparam int MASK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_RETIRE  = 2'd2
    } mfi_state_e;

    typedef struct packed {
        logic [XLEN-1:0]   inst;
        logic [XLEN-1:0]   pc_rdata;
        logic [XLEN-1:0]   pc_wdata;
        logic [XLEN-1:0]   mcr_rdata;
        logic [XLEN-1:0]   mcr_wdata;
        logic [REG_W-1:0]  src1_addr;
        logic [REG_W-1:0]  src2_addr;
        logic [REG_W-1:0]  src3_addr;
        logic [XLEN-1:0]   src1_rdata;
        logic [XLEN-1:0]   src2_rdata;
        logic [XLEN-1:0]   src3_rdata;
        logic [REG_W-1:0]  dest_addr;
        logic [XLEN-1:0]   dest_wdata;
        logic [XLEN-1:0]   mem_addr;
        logic [MASK_W-1:0] mem_rmask;
        logic [MASK_W-1:0] mem_wmask;
        logic [XLEN-1:0]   mem_rdata;
        logic [XLEN-1:0]   mem_wdata;
        logic              trap;
        logic              halt;
        logic              intr;
    } mfi_packet_t;

    // A new instruction starts with only its issue-time fields populated;
    // everything gathered later in COLLECT begins at zero.
    function automatic mfi_packet_t new_packet(input logic [XLEN-1:0] inst,
                                               input logic [XLEN-1:0] pc,
                                               input logic [XLEN-1:0] mcr);
        mfi_packet_t p;
        p           = '0;
        p.inst      = inst;
        p.pc_rdata  = pc;
        p.mcr_rdata = mcr;
        return p;
    endfunction

endpackage

// File: rtl/mfi_watchdog.sv
// COLLECT-phase watchdog. Implemented as a down-counter loaded with TIMEOUT
// when an instruction enters COLLECT; it expires during the COLLECT cycle
// whose 1-based index equals TIMEOUT (counter value 1). TIMEOUT=0 never expires.
module mfi_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic start,
    input  logic tick,
    output logic expired
);

    localparam int              CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count;

    // Load on COLLECT entry, count down while COLLECT persists, zero otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (start) begin
            count <= LOAD;
        end else if (tick && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign expired = (TIMEOUT != 0) && (count == ONE);

endmodule

// File: rtl/mfi_retire_tracker.sv
// MFI retire tracker: gathers issue, register-read, memory and writeback
// information for one instruction at a time and emits it as a single
// registered retire packet with a one-cycle mfi_valid strobe.
// Optional feature macro: MFI_MEM_TRACE_EN enables memory-access capture;
// without it the mem_* inputs are ignored and mfi_mem_* stay zero.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no instruction in flight, waiting for if_valid
// ST_COLLECT | instruction issued, gathering rd/mem until wb or watchdog
// ST_RETIRE  | packet presented on mfi_*, mfi_valid high for this cycle
module mfi_retire_tracker
    import mfi_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_inst,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_mcr,
    input  logic        rd_valid,
    input  logic [11:0] rd_addr,
    input  logic [95:0] rd_data,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_rmask,
    input  logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] mem_wdata,
    input  logic        wb_valid,
    input  logic [3:0]  wb_dest_addr,
    input  logic [31:0] wb_dest_data,
    input  logic [31:0] wb_pc_next,
    input  logic [31:0] wb_mcr,
    input  logic        wb_trap,
    input  logic        wb_halt,
    input  logic        wb_intr,
    output logic        busy,
    output logic        proto_err,
    output logic        mfi_valid,
    output logic [31:0] mfi_inst,
    output logic [31:0] mfi_pc_rdata,
    output logic [31:0] mfi_pc_wdata,
    output logic [31:0] mfi_mcr_rdata,
    output logic [31:0] mfi_mcr_wdata,
    output logic [31:0] mfi_dest_wdata,
    output logic [31:0] mfi_src1_rdata,
    output logic [31:0] mfi_src2_rdata,
    output logic [31:0] mfi_src3_rdata,
    output logic [31:0] mfi_mem_addr,
    output logic [31:0] mfi_mem_rdata,
    output logic [31:0] mfi_mem_wdata,
    output logic [3:0]  mfi_src1_addr,
    output logic [3:0]  mfi_src2_addr,
    output logic [3:0]  mfi_src3_addr,
    output logic [3:0]  mfi_dest_addr,
    output logic [3:0]  mfi_mem_rmask,
    output logic [3:0]  mfi_mem_wmask,
    output logic        mfi_trap,
    output logic        mfi_halt,
    output logic        mfi_intr
);

    mfi_state_e  state, state_nxt;
    mfi_packet_t work, work_nxt;   // packet being assembled
    mfi_packet_t pkt, pkt_nxt;     // last retired packet, drives mfi_*
    logic        busy_q, valid_q, err_q, err_set;
    logic        mem_seen;
    logic        wd_clear, wd_start, wd_tick, wd_expired;

`ifdef MFI_MEM_TRACE_EN
    assign mem_seen = mem_valid;
`else
    assign mem_seen = 1'b0;
`endif

    // Next-state, packet assembly and protocol-violation detection.
    always_comb begin
        state_nxt = state;
        work_nxt  = work;
        pkt_nxt   = pkt;
        err_set   = 1'b0;
        case (state)
            ST_COLLECT: begin
                // A second issue while one is in flight is dropped.
                err_set = if_valid;
                if (rd_valid) begin
                    work_nxt.src1_addr  = rd_addr[3:0];
                    work_nxt.src2_addr  = rd_addr[7:4];
                    work_nxt.src3_addr  = rd_addr[11:8];
                    work_nxt.src1_rdata = rd_data[31:0];
                    work_nxt.src2_rdata = rd_data[63:32];
                    work_nxt.src3_rdata = rd_data[95:64];
                end
                if (mem_seen) begin
                    work_nxt.mem_addr  = mem_addr;
                    work_nxt.mem_rmask = mem_rmask;
                    work_nxt.mem_wmask = mem_wmask;
                    work_nxt.mem_rdata = mem_rdata;
                    work_nxt.mem_wdata = mem_wdata;
                end
                // Writeback beats the watchdog when both land together.
                if (wb_valid) begin
                    work_nxt.dest_addr  = wb_dest_addr;
                    work_nxt.dest_wdata = wb_dest_data;
                    work_nxt.pc_wdata   = wb_pc_next;
                    work_nxt.mcr_wdata  = wb_mcr;
                    work_nxt.trap       = wb_trap;
                    work_nxt.halt       = wb_halt;
                    work_nxt.intr       = wb_intr;
                    pkt_nxt             = work_nxt;
                    state_nxt           = ST_RETIRE;
                end else if (wd_expired) begin
                    // Forced retire as a trap with architectural state unchanged.
                    work_nxt.dest_addr  = '0;
                    work_nxt.dest_wdata = '0;
                    work_nxt.pc_wdata   = work_nxt.pc_rdata;
                    work_nxt.mcr_wdata  = work_nxt.mcr_rdata;
                    work_nxt.trap       = 1'b1;
                    work_nxt.halt       = 1'b0;
                    work_nxt.intr       = 1'b0;
                    pkt_nxt             = work_nxt;
                    state_nxt           = ST_RETIRE;
                end
            end
            default: begin
                // IDLE and RETIRE behave identically: accept a new issue.
                err_set = rd_valid | wb_valid | mem_seen;
                if (if_valid) begin
                    work_nxt  = new_packet(if_inst, if_pc, if_mcr);
                    state_nxt = ST_COLLECT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    assign wd_start = (state != ST_COLLECT) && (state_nxt == ST_COLLECT);
    assign wd_tick  = (state == ST_COLLECT) && (state_nxt == ST_COLLECT);
    assign wd_clear = (state_nxt != ST_COLLECT);

    mfi_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .start   (wd_start),
        .tick    (wd_tick),
        .expired (wd_expired)
    );

    // FSM state and the working/retired packet registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            work  <= '0;
            pkt   <= '0;
        end else begin
            state <= state_nxt;
            work  <= work_nxt;
            pkt   <= pkt_nxt;
        end
    end

    // Registered status outputs; proto_err is sticky until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= (state_nxt == ST_COLLECT);
            valid_q <= (state_nxt == ST_RETIRE);
            err_q   <= err_q | err_set;
        end
    end

    assign busy           = busy_q;
    assign mfi_valid      = valid_q;
    assign proto_err      = err_q;
    assign mfi_inst       = pkt.inst;
    assign mfi_pc_rdata   = pkt.pc_rdata;
    assign mfi_pc_wdata   = pkt.pc_wdata;
    assign mfi_mcr_rdata  = pkt.mcr_rdata;
    assign mfi_mcr_wdata  = pkt.mcr_wdata;
    assign mfi_dest_wdata = pkt.dest_wdata;
    assign mfi_dest_addr  = pkt.dest_addr;
    assign mfi_src1_addr  = pkt.src1_addr;
    assign mfi_src2_addr  = pkt.src2_addr;
    assign mfi_src3_addr  = pkt.src3_addr;
    assign mfi_src1_rdata = pkt.src1_rdata;
    assign mfi_src2_rdata = pkt.src2_rdata;
    assign mfi_src3_rdata = pkt.src3_rdata;
    assign mfi_trap       = pkt.trap;
    assign mfi_halt       = pkt.halt;
    assign mfi_intr       = pkt.intr;

`ifdef MFI_MEM_TRACE_EN
    assign mfi_mem_addr  = pkt.mem_addr;
    assign mfi_mem_rmask = pkt.mem_rmask;
    assign mfi_mem_wmask = pkt.mem_wmask;
    assign mfi_mem_rdata = pkt.mem_rdata;
    assign mfi_mem_wdata = pkt.mem_wdata;
`else
    // Memory tracing compiled out: outputs tied low, leftover bits parked.
    logic unused_mem;
    assign unused_mem    = ^{mem_valid, pkt.mem_addr, pkt.mem_rmask, pkt.mem_wmask,
                             pkt.mem_rdata, pkt.mem_wdata};
    assign mfi_mem_addr  = '0;
    assign mfi_mem_rmask = '0;
    assign mfi_mem_wmask = '0;
    assign mfi_mem_rdata = '0;
    assign mfi_mem_wdata = '0;
`endif

endmodule

// File: doc/mfi_retire_tracker.md
MFI_RETIRE_TRACKER -- requirements
Module: mfi_retire_tracker

Interface
REQ-001 Parameter TIMEOUT, 255, max cycles in COLLECT before forced trap retire; 0 disables.
REQ-002 Ports (name direction width meaning):
  clock  input  1  sole clock, rising edge
  reset  input  1  asynchronous, active-high
  if_valid  input  1  instruction issued
  if_inst  input  32  instruction word
  if_pc  input  32  pc of instruction
  if_mcr  input  32  mcr value at issue
  rd_valid  input  1  register reads valid
  rd_addr  input  12  src1..src3 addrs, src1 in [3:0]
  rd_data  input  96  src1..src3 data, src1 in [31:0]
  mem_valid  input  1  memory access complete
  mem_addr  input  32  byte address
  mem_rmask  input  4  bytes read
  mem_wmask  input  4  bytes written
  mem_rdata  input  32  read data
  mem_wdata  input  32  write data
  wb_valid  input  1  instruction complete
  wb_dest_addr  input  4  dest register
  wb_dest_data  input  32  dest data
  wb_pc_next  input  32  next pc
  wb_mcr  input  32  mcr after instruction
  wb_trap  input  1  instruction trapped
  wb_halt  input  1  core halted
  wb_intr  input  1  interrupt taken
  busy  output  1  high in COLLECT
  proto_err  output  1  sticky protocol violation
  mfi_valid  output  1  one-cycle retire strobe
  mfi_inst, mfi_pc_rdata, mfi_pc_wdata, mfi_mcr_rdata, mfi_mcr_wdata, mfi_dest_wdata  output  32  packet fields
  mfi_src1/2/3_rdata, mfi_mem_addr, mfi_mem_rdata, mfi_mem_wdata  output  32  packet fields
  mfi_src1/2/3_addr, mfi_dest_addr, mfi_mem_rmask, mfi_mem_wmask  output  4  packet fields
  mfi_trap, mfi_halt, mfi_intr  output  1  packet flags

Function
REQ-003 FSM states IDLE, COLLECT, RETIRE; all outputs registered.
REQ-004 IDLE or RETIRE with if_valid: latch inst/pc/mcr, zero src/mem/dest/flag fields, go COLLECT.
REQ-005 COLLECT: rd_valid latches src fields; mem_valid latches mem fields; repeats overwrite (last wins).
REQ-006 COLLECT with wb_valid: latch dest, pc_wdata, mcr_wdata, trap/halt/intr, go RETIRE; rd/mem/wb valid same cycle all captured.
REQ-007 mfi_valid high exactly in RETIRE (one cycle); wb_valid at edge N gives mfi_valid during cycle N+1.
REQ-008 RETIRE without if_valid returns IDLE; back-to-back throughput one instruction per 2 cycles.
REQ-009 mfi_* fields hold last packet while mfi_valid low.
REQ-010 if_valid in COLLECT, or rd/mem/wb valid in IDLE/RETIRE: ignored, proto_err set until reset.
REQ-011 Watchdog counts COLLECT cycles from 1; at TIMEOUT without wb_valid: RETIRE with mfi_trap=1, pc_wdata=pc_rdata, mcr_wdata=mcr_rdata, dest fields 0; wb_valid on that cycle wins.

Reset
REQ-012 Reset asserted: state IDLE, counter 0, busy/proto_err/mfi_valid 0, all mfi_* fields 0, immediately.
REQ-013 Reset mid-COLLECT discards the partial packet; no mfi_valid emitted.

Configuration
REQ-014 Macro MFI_MEM_TRACE_EN defined: REQ-005 memory capture active.
REQ-015 Undefined: mem_* inputs ignored, mfi_mem_* tied 0, mem_valid never sets proto_err.

Structure
REQ-016 Package mfi_pkg: XLEN=32, REG_W=4, state enum mfi_state_e, struct mfi_packet_t.
REQ-017 Sub-module mfi_watchdog (counter, clear, expire flag) instantiated once.

Verification
REQ-018 if_inst=0xE0810002, pc=0x100, rd then wb dest=1 data=5 pc_next=0x104 -> one mfi_valid, fields match, src addrs 0 if rd_valid absent.
REQ-019 wb_valid in cycle after RETIRE if_valid: two packets, mfi_valid pulses 2 cycles apart.
REQ-020 TIMEOUT=4, no wb_valid -> mfi_valid on 5th cycle after issue, mfi_trap=1, pc_wdata=pc_rdata.
REQ-021 mem_valid addr=0x2000 wmask=0x3 wdata=0xBEEF -> packet mem fields match; with macro undefined all 0.
REQ-022 if_valid during COLLECT -> proto_err=1, packet retains first inst; reset clears.
REQ-023 reset during COLLECT -> outputs 0 immediately, no mfi_valid after release.
